micro_ucr_hash_iter: RTL and testbench

// - Iterative micro-UCR hash engine: one compression round per clock over a 16-word block.
// - Parametrised word width, round count and constants.
// - Valid/ready on both sides; optional chaining of the previous digest for multi-block messages.
// - Sits between the block feeder (nonce/message generator) and the digest comparator.

---
 rtl/micro_ucr_hash_pkg.sv | 37 +++
 rtl/micro_ucr_hash_if.sv | 40 ++++
 rtl/micro_ucr_hash_round.sv | 48 ++++
 rtl/micro_ucr_hash_iter.sv | 168 ++++++++++++++++
 tb/tb_micro_ucr_hash_iter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_ucr_hash_pkg.sv
// ============================================================================
// Module : micro_ucr_hash_pkg
// Brief  : Shared constants and types for the micro-UCR hash engine:
//          message geometry, schedule taps, FSM state encoding and the
//          default round constants / initial digest words.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package micro_ucr_hash_pkg;

  // Message block geometry
  localparam int MSG_WORDS = 16;

  // Schedule taps: W[j+16] = W[j+TAP_A] | (W[j+TAP_B] ^ W[j+TAP_C])
  localparam int TAP_A = 13;
  localparam int TAP_B = 7;
  localparam int TAP_C = 2;

  // Default 8-bit constants; wider variants zero-extend them
  localparam logic [7:0] DEF_K0  = 8'h99;
  localparam logic [7:0] DEF_K1  = 8'hA1;
  localparam logic [7:0] DEF_IV0 = 8'h01;
  localparam logic [7:0] DEF_IV1 = 8'h89;
  localparam logic [7:0] DEF_IV2 = 8'hFE;

  // Engine FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/micro_ucr_hash_if.sv
// ============================================================================
// Module : micro_ucr_hash_if
// Brief  : Block-in / digest-out handshake bundle of the hash engine.
// Ports  : in_valid/in_ready/in_chain/in_msg  block feeder -> engine
//          out_valid/out_ready/out_hash       engine -> digest consumer
//          busy                               engine status (high in RUN)
//          modport slave  : engine side
//          modport master : feeder/consumer side
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface micro_ucr_hash_if
  import micro_ucr_hash_pkg::*;
#(
  parameter int WORD_W = 8
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic                          in_chain;
  logic [MSG_WORDS*WORD_W-1:0]   in_msg;
  logic                          out_valid;
  logic                          out_ready;
  logic [3*WORD_W-1:0]           out_hash;
  logic                          busy;

  modport slave (
    input  in_valid, in_chain, in_msg, out_ready,
    output in_ready, out_valid, out_hash, busy
  );

  modport master (
    output in_valid, in_chain, in_msg, out_ready,
    input  in_ready, out_valid, out_hash, busy
  );

endinterface

`default_nettype wire

// File: rtl/micro_ucr_hash_round.sv
// ============================================================================
// Module : micro_ucr_hash_round
// Brief  : One combinational compression round.
//            x  = phase ? a|b : a^b
//            k  = phase ? K1  : K0
//            a' = b ^ c ; b' = c << SHIFT ; c' = x + k + w   (mod 2^WORD_W)
// Ports  : a, b, c   in   current state words
//          w         in   schedule word for this round
//          phase     in   0: early rounds (XOR/K0), 1: late rounds (OR/K1)
//          a_next, b_next, c_next  out  state words after the round
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module micro_ucr_hash_round
  import micro_ucr_hash_pkg::*;
#(
  parameter int                WORD_W = 8,
  parameter int                SHIFT  = 4,
  parameter logic [WORD_W-1:0] K0     = WORD_W'(DEF_K0),
  parameter logic [WORD_W-1:0] K1     = WORD_W'(DEF_K1)
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] w,
  input  logic              phase,
  output logic [WORD_W-1:0] a_next,
  output logic [WORD_W-1:0] b_next,
  output logic [WORD_W-1:0] c_next
);

  logic [WORD_W-1:0] x;
  logic [WORD_W-1:0] k;

  always_comb begin
    x = phase ? (a | b) : (a ^ b);
    k = phase ? K1 : K0;
  end

  assign a_next = b ^ c;
  // Shift stays in WORD_W context: zero-filled and truncated
  assign b_next = c << SHIFT;
  assign c_next = x + k + w;

endmodule

`default_nettype wire

// File: rtl/micro_ucr_hash_iter.sv
// ============================================================================
// Module : micro_ucr_hash_iter
// Brief  : Iterative micro-UCR hash engine, one round per clock over a
//          16-word block, with optional chaining of the previous digest.
// Ports  : clk    in  clock, rising edge
//          reset  in  synchronous, active-high
//          bus    micro_ucr_hash_if.slave
//                   in_valid/in_ready/in_chain/in_msg : block input
//                   out_valid/out_ready/out_hash      : digest output
//                   busy                              : high while hashing
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module micro_ucr_hash_iter
  import micro_ucr_hash_pkg::*;
#(
  parameter int                WORD_W = 8,
  parameter int                ROUNDS = 32,
  parameter int                SPLIT  = 16,
  parameter int                SHIFT  = 4,
  parameter logic [WORD_W-1:0] K0     = WORD_W'(DEF_K0),
  parameter logic [WORD_W-1:0] K1     = WORD_W'(DEF_K1),
  parameter logic [WORD_W-1:0] IV0    = WORD_W'(DEF_IV0),
  parameter logic [WORD_W-1:0] IV1    = WORD_W'(DEF_IV1),
  parameter logic [WORD_W-1:0] IV2    = WORD_W'(DEF_IV2)
) (
  input  logic               clk,
  input  logic               reset,
  micro_ucr_hash_if.slave    bus
);

  localparam int                  CNT_W   = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0]    LAST    = CNT_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0]    SPLIT_C = CNT_W'(SPLIT);
  localparam logic [3*WORD_W-1:0] IV_ALL  = {IV0, IV1, IV2};

  state_t              state;
  state_t              state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [WORD_W-1:0]   win [MSG_WORDS];
  logic [WORD_W-1:0]   a;
  logic [WORD_W-1:0]   b;
  logic [WORD_W-1:0]   c;
  logic [WORD_W-1:0]   h0;
  logic [WORD_W-1:0]   h1;
  logic [WORD_W-1:0]   h2;
  logic [3*WORD_W-1:0] chain;
  logic [3*WORD_W-1:0] hash;

  logic                accept;
  logic                last_round;
  logic                phase;
  logic [WORD_W-1:0]   a_nx;
  logic [WORD_W-1:0]   b_nx;
  logic [WORD_W-1:0]   c_nx;
  logic [3*WORD_W-1:0] iv_sel;
  logic [3*WORD_W-1:0] digest;
  logic                acc_rdy;
  logic                dig_vld;
  logic                run_busy;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_round = (state == RUN) && (cnt == LAST);
  assign phase      = (cnt > SPLIT_C);
  // Chain register resets to the IVs, so chaining before any digest is safe
  assign iv_sel     = bus.in_chain ? chain : IV_ALL;
  // Feed-forward taken from this round's outputs so the digest registers on
  // the same edge as the final round
  assign digest     = {h0 + a_nx, h1 + b_nx, h2 + c_nx};

  micro_ucr_hash_round #(
    .WORD_W (WORD_W),
    .SHIFT  (SHIFT),
    .K0     (K0),
    .K1     (K1)
  ) u_round (
    .a      (a),
    .b      (b),
    .c      (c),
    .w      (win[0]),
    .phase  (phase),
    .a_next (a_nx),
    .b_next (b_nx),
    .c_next (c_nx)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_round) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    acc_rdy  = 1'b0;
    dig_vld  = 1'b0;
    run_busy = 1'b0;
    case (state)
      IDLE:    acc_rdy  = 1'b1;
      RUN:     run_busy = 1'b1;
      DONE:    dig_vld  = 1'b1;
      default: acc_rdy  = 1'b0;
    endcase
  end

  assign bus.in_ready  = acc_rdy;
  assign bus.out_valid = dig_vld;
  assign bus.busy      = run_busy;
  assign bus.out_hash  = hash;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      h0    <= '0;
      h1    <= '0;
      h2    <= '0;
      hash  <= '0;
      chain <= IV_ALL;
      for (int i = 0; i < MSG_WORDS; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int i = 0; i < MSG_WORDS; i++)
              win[i] <= bus.in_msg[i*WORD_W +: WORD_W];
            {a, b, c}    <= iv_sel;
            {h0, h1, h2} <= iv_sel;
            cnt          <= '0;
          end
        end
        RUN: begin
          a <= a_nx;
          b <= b_nx;
          c <= c_nx;
          // win[0] always holds W[j]; the new tail word is W[j+16]
          for (int i = 0; i < MSG_WORDS - 1; i++) win[i] <= win[i+1];
          win[MSG_WORDS-1] <= win[TAP_A] | (win[TAP_B] ^ win[TAP_C]);
          if (last_round) begin
            hash  <= digest;
            chain <= digest;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_micro_ucr_hash_iter.sv
// ============================================================================
// Module : tb_micro_ucr_hash_iter
// Brief  : Self-checking bench for micro_ucr_hash_iter. Two engines are
//          instantiated (8-bit/32 rounds and 16-bit/24 rounds) and compared
//          against a word-list reference of the hash algorithm.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_micro_ucr_hash_iter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  micro_ucr_hash_if #(.WORD_W(8))  bus8 ();
  micro_ucr_hash_if #(.WORD_W(16)) bus16 ();

  micro_ucr_hash_iter #(.WORD_W(8), .ROUNDS(32)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  micro_ucr_hash_iter #(.WORD_W(16), .ROUNDS(24)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  int checks   = 0;
  int failures = 0;

  int acc8 = 0, del8 = 0, acc16 = 0, del16 = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (bus8.in_valid && bus8.in_ready)    acc8  <= acc8 + 1;
      if (bus8.out_valid && bus8.out_ready)  del8  <= del8 + 1;
      if (bus16.in_valid && bus16.in_ready)  acc16 <= acc16 + 1;
      if (bus16.out_valid && bus16.out_ready) del16 <= del16 + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expand the full word list, then run the rounds on plain values
  function automatic logic [47:0] model(input int ww, input int rounds,
                                        input logic [255:0] msg, input logic [47:0] iv);
    logic [63:0] mask, a, b, c, h0, h1, h2, x, k, na, nb, nc;
    logic [63:0] w [0:79];
    mask = (64'd1 << ww) - 64'd1;
    h0 = 64'(iv >> (2*ww)) & mask;
    h1 = 64'(iv >> ww) & mask;
    h2 = 64'(iv) & mask;
    for (int i = 0; i < 16; i++) w[i] = 64'(msg >> (i*ww)) & mask;
    for (int j = 16; j < rounds + 16; j++) w[j] = w[j-3] | (w[j-9] ^ w[j-14]);
    a = h0; b = h1; c = h2;
    for (int j = 0; j < rounds; j++) begin
      if (j <= 16) begin x = a ^ b; k = 64'h99; end
      else         begin x = a | b; k = 64'hA1; end
      na = b ^ c;
      nb = (c << 4) & mask;
      nc = (x + k + w[j]) & mask;
      a = na; b = nb; c = nc;
    end
    return 48'((((h0 + a) & mask) << (2*ww)) | (((h1 + b) & mask) << ww) | ((h2 + c) & mask));
  endfunction

  function automatic logic get_in_ready(input int cfg);
    return (cfg == 0) ? bus8.in_ready : bus16.in_ready;
  endfunction

  function automatic logic get_out_valid(input int cfg);
    return (cfg == 0) ? bus8.out_valid : bus16.out_valid;
  endfunction

  function automatic logic get_busy(input int cfg);
    return (cfg == 0) ? bus8.busy : bus16.busy;
  endfunction

  function automatic logic [47:0] get_hash(input int cfg);
    return (cfg == 0) ? {24'd0, bus8.out_hash} : bus16.out_hash;
  endfunction

  task automatic drive_in(input int cfg, input logic v, input logic ch, input logic [255:0] msg);
    if (cfg == 0) begin
      bus8.in_valid = v; bus8.in_chain = ch; bus8.in_msg = msg[127:0];
    end else begin
      bus16.in_valid = v; bus16.in_chain = ch; bus16.in_msg = msg;
    end
  endtask

  task automatic drive_ordy(input int cfg, input logic r);
    if (cfg == 0) bus8.out_ready = r;
    else          bus16.out_ready = r;
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one block, then hold the digest for 'stall' cycles before taking it.
  // lat counts falling edges from the accept edge until out_valid is seen.
  task automatic send(input int cfg, input logic [255:0] msg, input logic ch, input int stall,
                      input logic pulse, output logic [47:0] dig, output int lat);
    int n;
    @(negedge clk);
    drive_ordy(cfg, 1'b0);
    drive_in(cfg, 1'b1, ch, msg);
    n = 0;
    while (!get_in_ready(cfg) && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    // Scrambled inputs after the accept must not disturb the running block
    drive_in(cfg, 1'b0, ~ch, rand256());
    lat = 1;
    while (!get_out_valid(cfg) && lat < 200) begin @(negedge clk); lat++; end
    check("out_valid_seen", 64'(get_out_valid(cfg)), 64'd1);
    dig = get_hash(cfg);
    for (int s = 0; s < stall; s++) begin
      check("hold_valid", 64'(get_out_valid(cfg)), 64'd1);
      check("hold_hash", 64'(get_hash(cfg)), 64'(dig));
      check("hold_in_ready", 64'(get_in_ready(cfg)), 64'd0);
      drive_in(cfg, pulse && (s % 2 == 1), ch, rand256());
      @(negedge clk);
    end
    drive_in(cfg, 1'b0, ch, msg);
    drive_ordy(cfg, 1'b1);
    @(negedge clk);
    drive_ordy(cfg, 1'b0);
    check("release_valid", 64'(get_out_valid(cfg)), 64'd0);
    check("release_ready", 64'(get_in_ready(cfg)), 64'd1);
  endtask

  task automatic rand_run(input int cfg, input int nblk);
    int ww, rounds, lat;
    logic [47:0] ivd, last, iv, exp, dig;
    logic [255:0] m;
    logic ch;
    ww     = (cfg == 0) ? 8 : 16;
    rounds = (cfg == 0) ? 32 : 24;
    ivd    = (cfg == 0) ? 48'h0189FE : 48'h0001_0089_00FE;
    last   = ivd;
    for (int i = 0; i < nblk; i++) begin
      m = rand256();
      if (cfg == 0) m[255:128] = '0;
      ch  = 1'($urandom_range(0, 1));
      iv  = ch ? last : ivd;
      exp = model(ww, rounds, m, iv);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(cfg, m, ch, $urandom_range(0, 3), 1'b1, dig, lat);
      check("rand_digest", 64'(dig), 64'(exp));
      check("rand_latency", 64'(lat), 64'(rounds + 1));
      last = exp;
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] dig, dig2;
    logic [255:0] zero, m;
    int lat, t, a8, d8, a16, d16;
    int acc_t[$];
    zero = '0;
    reset = 1'b1;
    drive_in(0, 1'b0, 1'b0, zero);
    drive_in(1, 1'b0, 1'b0, zero);
    drive_ordy(0, 1'b0);
    drive_ordy(1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_busy", 64'(bus8.busy), 64'd0);
    check("rst_hash", 64'(bus8.out_hash), 64'd0);
    check("rst16_in_ready", 64'(bus16.in_ready), 64'd1);
    check("rst16_hash", 64'(bus16.out_hash), 64'd0);
    reset = 1'b0;

    // Zero block, fixed IV
    send(0, zero, 1'b0, 0, 1'b0, dig, lat);
    check("zero_hash", 64'(dig), 64'h00C18985);
    check("zero_latency", 64'(lat), 64'd33);

    // Same block chained onto the previous digest
    send(0, zero, 1'b1, 0, 1'b0, dig2, lat);
    check("chain_hash", 64'(dig2), 64'(model(8, 32, zero, 48'hC18985)));
    check("chain_differs", 64'(dig2 != 48'hC18985), 64'd1);

    // Backpressure with ignored in_valid pulses
    m = rand256(); m[255:128] = '0;
    send(0, m, 1'b0, 10, 1'b1, dig, lat);
    check("bp_hash", 64'(dig), 64'(model(8, 32, m, 48'h0189FE)));

    // Reset in the middle of a block
    @(negedge clk);
    drive_in(0, 1'b1, 1'b0, zero);
    @(negedge clk);
    drive_in(0, 1'b0, 1'b0, zero);
    repeat (20) @(negedge clk);
    check("mid_busy", 64'(get_busy(0)), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_in_ready", 64'(bus8.in_ready), 64'd1);
    check("abort_out_valid", 64'(bus8.out_valid), 64'd0);
    check("abort_hash", 64'(bus8.out_hash), 64'd0);
    check("abort_busy", 64'(bus8.busy), 64'd0);
    send(0, zero, 1'b1, 0, 1'b0, dig, lat);
    check("post_abort_hash", 64'(dig), 64'h00C18985);

    // Back-to-back: in_valid and out_ready held high
    m = rand256();
    @(negedge clk);
    drive_in(0, 1'b1, 1'b0, m);
    drive_ordy(0, 1'b1);
    t = 0;
    while (t < 400 && acc_t.size() < 4) begin
      if (bus8.in_ready) acc_t.push_back(t);
      @(negedge clk);
      t++;
    end
    drive_in(0, 1'b0, 1'b0, zero);
    check("b2b_accepts", 64'(acc_t.size()), 64'd4);
    for (int i = 1; i < acc_t.size(); i++)
      check("b2b_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'd34);
    t = 0;
    while (!bus8.in_ready && t < 100) begin @(negedge clk); t++; end
    drive_ordy(0, 1'b0);

    // Random blocks on both widths, from a clean chain register
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    a8 = acc8; d8 = del8; a16 = acc16; d16 = del16;
    fork
      rand_run(0, 1000);
      rand_run(1, 1000);
    join
    @(negedge clk);
    check("count8", 64'(del8 - d8), 64'(acc8 - a8));
    check("count16", 64'(del16 - d16), 64'(acc16 - a16));
    check("count8_total", 64'(acc8 - a8), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
